// File: rtl/ball_cmd_sched.sv
// ball_cmd_sched
// Queues keyboard motion commands and presents each one to the ball block
// for a fixed number of video frames.
//
// The block holds up to four commands in arrival order. On each frame tick,
// the front command becomes the active keycode and stays active for
// HOLD_FRAMES frames. The next queued command follows with no gap frame.
// Esc (8'h29) empties the queue and stops the active command at once.
//
// Ports
//   Clk         system clock
//   Reset_n     asynchronous active-low reset
//   frame_tick  one-cycle pulse at the start of each video frame
//   key_valid   one-cycle strobe: key_code holds a new key event
//   key_code    USB HID keycode of the event
//   key_ready   queue has room (taken from registered count only)
//   keycode     active motion command, 8'h00 when idle
//   busy        a command is being held
//   fifo_count  number of queued commands, 0..4
//   drop_cnt    motion events refused because the queue was full (saturates)
module ball_cmd_sched #(
  parameter int HOLD_FRAMES = 8,
  parameter int DEPTH       = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       key_ready,
  output logic [7:0] keycode,
  output logic       busy,
  output logic [2:0] fifo_count,
  output logic [7:0] drop_cnt
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [7:0] RELOAD  = 8'(HOLD_FRAMES - 1);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  state_e     state_q, state_d;
  logic [7:0] keycode_q, keycode_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [2:0] count_q, count_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];

  logic       ready_s;
  logic       is_motion_s;
  logic       push_s;
  logic       drop_s;
  logic       flush_s;
  logic       pop_s;
  logic [7:0] head_s;

  // Next-state logic for the queue, the hold FSM and the drop counter
  always_comb begin
    state_d     = state_q;
    keycode_d   = keycode_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;

    ready_s     = (count_q < DEPTH_C);
    is_motion_s = (key_code == 8'h1A) || (key_code == 8'h16) ||
                  (key_code == 8'h04) || (key_code == 8'h07);
    push_s      = key_valid && is_motion_s && ready_s;
    drop_s      = key_valid && is_motion_s && !ready_s;
    flush_s     = key_valid && (key_code == 8'h29);
    head_s      = mem_q[rd_ptr_q];

    // The emptiness check uses the registered count. A command pushed on
    // this edge can be popped only on a later tick.
    pop_s = 1'b0;
    if (frame_tick && !flush_s && (count_q != 3'd0)) begin
      case (state_q)
        IDLE:    pop_s = 1'b1;
        HOLD:    pop_s = (frame_cnt_q == 8'd0);
        default: pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end

    if (flush_s) begin
      state_d     = IDLE;
      keycode_d   = 8'h00;
      frame_cnt_d = 8'd0;
      count_d     = 3'd0;
      wr_ptr_d    = 2'd0;
      rd_ptr_d    = 2'd0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = key_code;
        wr_ptr_d        = wr_ptr_q + 2'd1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + 2'd1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + 3'(push_s) - 3'(pop_s);

      if (frame_tick) begin
        case (state_q)
          IDLE: begin
            if (pop_s) begin
              keycode_d   = head_s;
              frame_cnt_d = RELOAD;
              state_d     = HOLD;
            end else begin
              state_d = IDLE;
            end
          end
          HOLD: begin
            if (frame_cnt_q != 8'd0) begin
              frame_cnt_d = frame_cnt_q - 8'd1;
            end else if (pop_s) begin
              // Load the next command directly, with no idle frame between.
              keycode_d   = head_s;
              frame_cnt_d = RELOAD;
            end else begin
              keycode_d = 8'h00;
              state_d   = IDLE;
            end
          end
          default: begin
            keycode_d = 8'h00;
            state_d   = IDLE;
          end
        endcase
      end else begin
        state_d = state_q;
      end
    end

    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State, queue storage and counters
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      keycode_q   <= 8'h00;
      frame_cnt_q <= 8'd0;
      drop_cnt_q  <= 8'd0;
      count_q     <= 3'd0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      keycode_q   <= keycode_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  assign key_ready  = ready_s;
  assign keycode    = keycode_q;
  assign busy       = (state_q == HOLD);
  assign fifo_count = count_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
